// File: rtl/pq_event_dispatcher.sv
// Front-end for the heap priority queue: takes events in, keeps the smallest one
// in a single dispatch slot, and issues at most one enqueue/dequeue per cycle.
module pq_event_dispatcher #(
    parameter int WIDTH   = 32,
    parameter int CMP_WID = 32,
    parameter int DEPTH   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ev_in_valid,
    output logic               ev_in_ready,
    input  logic [WIDTH-1:0]   ev_in_data,
    output logic               ev_out_valid,
    input  logic               ev_out_ready,
    output logic [WIDTH-1:0]   ev_out_data,
    output logic               q_enq,
    output logic               q_deq,
    output logic [WIDTH-1:0]   q_inp_data,
    input  logic [WIDTH-1:0]   q_out_data,
    input  logic [DEPTH-1:0]   q_elem_cnt,
    input  logic               q_full,
    input  logic               q_empty,
    output logic [CMP_WID-1:0] min_key,
    output logic [31:0]        disp_cnt
);

    function automatic logic [CMP_WID-1:0] key_of(input logic [WIDTH-1:0] x);
        return x[CMP_WID-1:0];
    endfunction

    function automatic logic [CMP_WID-1:0] min_of(input logic [CMP_WID-1:0] a,
                                                  input logic [CMP_WID-1:0] b);
        return (a < b) ? a : b;
    endfunction

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_BYPASS,
        OP_ENQ_BUBBLE,
        OP_SWAP,
        OP_ENQ_IN,
        OP_REFILL,
        OP_DRAIN
    } op_e;

    logic             vld_p0;
    logic [WIDTH-1:0] slot_p0;
    logic [31:0]      disp_cnt_p0;

    logic in_fire, out_fire, slot_free;
    logic in_lt_head, in_lt_slot;
    op_e  op;

    assign ev_in_ready = rst_n & ~q_full;
    assign in_fire     = ev_in_valid & ev_in_ready;
    assign out_fire    = vld_p0 & ev_out_ready;
    assign slot_free   = ~vld_p0 | out_fire;
    assign in_lt_head  = key_of(ev_in_data) < key_of(q_out_data);
    assign in_lt_slot  = key_of(ev_in_data) < key_of(slot_p0);

    // Strict compares: an equal key never overtakes, so older events leave first.
    always_comb begin
        op = OP_HOLD;
        if (in_fire) begin
            if (slot_free)
                op = (q_empty || in_lt_head) ? OP_BYPASS : OP_ENQ_BUBBLE;
            else
                op = in_lt_slot ? OP_SWAP : OP_ENQ_IN;
        end else if (slot_free) begin
            op = q_empty ? OP_DRAIN : OP_REFILL;
        end
    end

    assign q_enq      = rst_n & ((op == OP_ENQ_BUBBLE) | (op == OP_SWAP) | (op == OP_ENQ_IN));
    assign q_deq      = rst_n & (op == OP_REFILL);
    assign q_inp_data = (op == OP_SWAP) ? slot_p0 : ev_in_data;

    // Stage p0: dispatch slot and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0      <= 1'b0;
            slot_p0     <= '0;
            disp_cnt_p0 <= '0;
        end else begin
            if (out_fire)
                disp_cnt_p0 <= disp_cnt_p0 + 32'd1;
            case (op)
                OP_BYPASS: begin
                    vld_p0  <= 1'b1;
                    slot_p0 <= ev_in_data;
                end
                OP_SWAP:   slot_p0 <= ev_in_data;
                OP_REFILL: begin
                    vld_p0  <= 1'b1;
                    slot_p0 <= q_out_data;
                end
                OP_ENQ_BUBBLE, OP_DRAIN: vld_p0 <= 1'b0;
                default: ;
            endcase
        end
    end

    assign ev_out_valid = vld_p0;
    assign ev_out_data  = slot_p0;
    assign disp_cnt     = disp_cnt_p0;

    always_comb begin
        if (vld_p0)
            min_key = q_empty ? key_of(slot_p0) : min_of(key_of(slot_p0), key_of(q_out_data));
        else if (!q_empty)
            min_key = key_of(q_out_data);
        else
            min_key = '1;
    end

    a_no_enq_deq: assert property (@(posedge clk) disable iff (!rst_n) !(q_enq && q_deq));
    a_no_enq_full: assert property (@(posedge clk) disable iff (!rst_n) q_enq |-> !q_full);
    a_no_deq_empty: assert property (@(posedge clk) disable iff (!rst_n) q_deq |-> !q_empty);
    a_cnt_empty: assert property (@(posedge clk) disable iff (!rst_n) (q_elem_cnt != '0) == !q_empty);
    a_slot_order: assert property (@(posedge clk) disable iff (!rst_n)
        (vld_p0 && !q_empty) |-> (key_of(slot_p0) <= key_of(q_out_data)));

endmodule

// File: tb/tb_pq_event_dispatcher.sv
// Directed bench for pq_event_dispatcher with an ideal sorted-queue model standing in for the heap.
module tb_pq_event_dispatcher;

    localparam int WIDTH = 32;
    localparam int CMP_WID = 32;
    localparam int DEPTH = 5;
    localparam int QCAP = 31;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               ev_in_valid = 1'b0;
    logic               ev_in_ready;
    logic [WIDTH-1:0]   ev_in_data = '0;
    logic               ev_out_valid;
    logic               ev_out_ready = 1'b0;
    logic [WIDTH-1:0]   ev_out_data;
    logic               q_enq, q_deq;
    logic [WIDTH-1:0]   q_inp_data;
    logic [WIDTH-1:0]   q_out_data;
    logic [DEPTH-1:0]   q_elem_cnt;
    logic               q_full, q_empty;
    logic [CMP_WID-1:0] min_key;
    logic [31:0]        disp_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pq_event_dispatcher #(.WIDTH(WIDTH), .CMP_WID(CMP_WID), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ev_in_valid(ev_in_valid), .ev_in_ready(ev_in_ready), .ev_in_data(ev_in_data),
        .ev_out_valid(ev_out_valid), .ev_out_ready(ev_out_ready), .ev_out_data(ev_out_data),
        .q_enq(q_enq), .q_deq(q_deq), .q_inp_data(q_inp_data),
        .q_out_data(q_out_data), .q_elem_cnt(q_elem_cnt), .q_full(q_full), .q_empty(q_empty),
        .min_key(min_key), .disp_cnt(disp_cnt)
    );

    // Ideal priority queue: sorted array, stable for equal keys.
    logic [WIDTH-1:0] mem [0:31];
    int qcnt;
    int ins_pos;

    always_comb begin
        ins_pos = 0;
        for (int i = 0; i < 32; i++)
            if (i < qcnt && mem[i] <= q_inp_data) ins_pos = i + 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt <= 0;
        end else if (q_enq) begin
            for (int i = 1; i < 32; i++)
                if (i > ins_pos && i <= qcnt) mem[i] <= mem[i-1];
            mem[ins_pos] <= q_inp_data;
            qcnt <= qcnt + 1;
        end else if (q_deq) begin
            for (int i = 0; i < 31; i++) mem[i] <= mem[i+1];
            qcnt <= qcnt - 1;
        end
    end

    assign q_empty    = (qcnt == 0);
    assign q_full     = (qcnt == QCAP);
    assign q_elem_cnt = qcnt[DEPTH-1:0];
    assign q_out_data = q_empty ? '0 : mem[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_data;
        logic        e_enq;
        logic        e_deq;
        logic [31:0] e_qin;
        logic [31:0] e_min;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic vin, input logic [31:0] din, input logic rdy,
                                input logic e_vld, input logic [31:0] e_data,
                                input logic e_enq, input logic e_deq, input logic [31:0] e_qin,
                                input logic [31:0] e_min, input logic [31:0] e_cnt);
        vec_t v;
        v.vin = vin; v.din = din; v.rdy = rdy; v.e_vld = e_vld; v.e_data = e_data;
        v.e_enq = e_enq; v.e_deq = e_deq; v.e_qin = e_qin; v.e_min = e_min; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t vecs [25];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ev;
        bit done;

        //          vin din    rdy  vld data   enq deq qin    min    cnt
        vecs[0]  = mk(1, 32'h10, 1,  0, 32'h0,  0, 0, 32'h0,  ONES,  0);
        vecs[1]  = mk(0, 32'h0,  1,  1, 32'h10, 0, 0, 32'h0,  32'h10, 0);
        vecs[2]  = mk(0, 32'h0,  0,  0, 32'h0,  0, 0, 32'h0,  ONES,  1);
        vecs[3]  = mk(1, 32'h30, 0,  0, 32'h0,  0, 0, 32'h0,  ONES,  1);
        vecs[4]  = mk(1, 32'h20, 0,  1, 32'h30, 1, 0, 32'h30, 32'h30, 1);
        vecs[5]  = mk(1, 32'h40, 0,  1, 32'h20, 1, 0, 32'h40, 32'h20, 1);
        vecs[6]  = mk(0, 32'h0,  1,  1, 32'h20, 0, 1, 32'h0,  32'h20, 1);
        vecs[7]  = mk(0, 32'h0,  1,  1, 32'h30, 0, 1, 32'h0,  32'h30, 2);
        vecs[8]  = mk(0, 32'h0,  1,  1, 32'h40, 0, 0, 32'h0,  32'h40, 3);
        vecs[9]  = mk(0, 32'h0,  0,  0, 32'h0,  0, 0, 32'h0,  ONES,  4);
        vecs[10] = mk(1, 32'h50, 0,  0, 32'h0,  0, 0, 32'h0,  ONES,  4);
        vecs[11] = mk(1, 32'h50, 0,  1, 32'h50, 1, 0, 32'h50, 32'h50, 4);
        vecs[12] = mk(0, 32'h0,  0,  1, 32'h50, 0, 0, 32'h0,  32'h50, 4);
        vecs[13] = mk(0, 32'h0,  1,  1, 32'h50, 0, 1, 32'h0,  32'h50, 4);
        vecs[14] = mk(0, 32'h0,  1,  1, 32'h50, 0, 0, 32'h0,  32'h50, 5);
        vecs[15] = mk(0, 32'h0,  0,  0, 32'h0,  0, 0, 32'h0,  ONES,  6);
        vecs[16] = mk(1, 32'h03, 0,  0, 32'h0,  0, 0, 32'h0,  ONES,  6);
        vecs[17] = mk(1, 32'h05, 0,  1, 32'h03, 1, 0, 32'h05, 32'h03, 6);
        vecs[18] = mk(1, 32'h08, 1,  1, 32'h03, 1, 0, 32'h08, 32'h03, 6);
        vecs[19] = mk(0, 32'h0,  0,  0, 32'h0,  0, 1, 32'h0,  32'h05, 7);
        vecs[20] = mk(0, 32'h0,  0,  1, 32'h05, 0, 0, 32'h0,  32'h05, 7);
        vecs[21] = mk(1, 32'h02, 1,  1, 32'h05, 0, 0, 32'h0,  32'h05, 7);
        vecs[22] = mk(0, 32'h0,  1,  1, 32'h02, 0, 1, 32'h0,  32'h02, 8);
        vecs[23] = mk(0, 32'h0,  1,  1, 32'h08, 0, 0, 32'h0,  32'h08, 9);
        vecs[24] = mk(0, 32'h0,  0,  0, 32'h0,  0, 0, 32'h0,  ONES,  10);

        // Reset state
        #3;
        chk("rst_vld", 32'(ev_out_valid), 0);
        chk("rst_data", ev_out_data, 0);
        chk("rst_cnt", disp_cnt, 0);
        chk("rst_enq", 32'(q_enq), 0);
        chk("rst_deq", 32'(q_deq), 0);
        chk("rst_ready", 32'(ev_in_ready), 0);
        #9 rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            ev_in_valid = vecs[i].vin;
            ev_in_data = vecs[i].din;
            ev_out_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_vld", i), 32'(ev_out_valid), 32'(vecs[i].e_vld));
            if (vecs[i].e_vld) chk($sformatf("v%0d_data", i), ev_out_data, vecs[i].e_data);
            chk($sformatf("v%0d_enq", i), 32'(q_enq), 32'(vecs[i].e_enq));
            chk($sformatf("v%0d_deq", i), 32'(q_deq), 32'(vecs[i].e_deq));
            if (vecs[i].e_enq) chk($sformatf("v%0d_qin", i), q_inp_data, vecs[i].e_qin);
            chk($sformatf("v%0d_min", i), min_key, vecs[i].e_min);
            chk($sformatf("v%0d_cnt", i), disp_cnt, vecs[i].e_cnt);
            chk($sformatf("v%0d_ready", i), 32'(ev_in_ready), 1);
        end

        // Fill: 0x100 takes the slot, 0x101..0x11F fill the queue to 31 entries.
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            ev_in_valid = 1'b1;
            ev_in_data = 32'h100 + 32'(i);
            ev_out_ready = 1'b0;
            @(negedge clk);
            chk($sformatf("fill%0d_ready", i), 32'(ev_in_ready), 1);
            if (i > 0) begin
                chk($sformatf("fill%0d_enq", i), 32'(q_enq), 1);
                chk($sformatf("fill%0d_qin", i), q_inp_data, 32'h100 + 32'(i));
            end
        end
        @(posedge clk); #1;
        ev_in_data = 32'h1FF;
        @(negedge clk);
        chk("full_ready", 32'(ev_in_ready), 0);
        chk("full_enq", 32'(q_enq), 0);
        chk("full_slot", ev_out_data, 32'h100);
        chk("full_min", min_key, 32'h100);
        @(posedge clk); #1;
        ev_out_ready = 1'b1;
        @(negedge clk);
        chk("full_refill_deq", 32'(q_deq), 1);
        chk("full_refill_enq", 32'(q_enq), 0);

        // Drain in ascending order starting from the refilled 0x101.
        exp_ev = 32'h101;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            ev_in_valid = 1'b0;
            @(negedge clk);
            if (c == 0) chk("unfull_ready", 32'(ev_in_ready), 1);
            if (ev_out_valid && ev_out_ready) begin
                chk($sformatf("drain_%0h", exp_ev), ev_out_data, 32'(exp_ev));
                exp_ev++;
                if (exp_ev == 32'h120) done = 1'b1;
            end
        end
        if (!done) chk("drain_timeout", 32'(exp_ev), 32'h120);
        @(posedge clk); #1;
        ev_out_ready = 1'b0;
        @(negedge clk);
        chk("drain_vld", 32'(ev_out_valid), 0);
        chk("drain_cnt", disp_cnt, 42);
        chk("drain_min", min_key, ONES);

        // Asynchronous reset with slot valid and queue non-empty.
        @(posedge clk); #1;
        ev_in_valid = 1'b1; ev_in_data = 32'h7;
        @(posedge clk); #1;
        ev_in_data = 32'h9;
        @(posedge clk); #1;
        ev_in_data = 32'hA;
        #2;
        chk("prerst_enq", 32'(q_enq), 1);
        chk("prerst_vld", 32'(ev_out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(ev_out_valid), 0);
        chk("mid_rst_data", ev_out_data, 0);
        chk("mid_rst_enq", 32'(q_enq), 0);
        chk("mid_rst_deq", 32'(q_deq), 0);
        chk("mid_rst_cnt", disp_cnt, 0);
        chk("mid_rst_ready", 32'(ev_in_ready), 0);
        @(negedge clk);
        ev_in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_min", min_key, ONES);
        @(posedge clk); #1;
        chk("post_rst_vld", 32'(ev_out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
